// File: rtl/float_multi_pkg.sv
// float_multi_pkg
// Shared FP16 (IEEE-754 binary16) format constants and the packed operand
// view used by the float_multi datapath.
package float_multi_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_lzc11.sv
// fp16_lzc11
// 11-bit leading-zero counter, used to normalise subnormal FP16 significands.
// Ports:
//   in_i  [10:0]  significand {hidden, frac}
//   cnt_o [3:0]   number of leading zeros (11 when in_i is all zero)
module fp16_lzc11 (
  input  logic [10:0] in_i,
  output logic [3:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (in_i[i]) cnt_o = 4'(10 - i);
    end
  end

endmodule

// File: rtl/float_multi.sv
// float_multi
// FP16 multiplier, round-to-nearest-even, one output register stage
// (latency 1, one product per clock).
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all outputs)
//   num1, num2 [15:0]   FP16 operands
//   result [15:0]       registered product
//   overflow            finite operands overflowed to +/-inf
//   zero                result magnitude is 0
//   nan                 result is the canonical quiet NaN
//   precision_lost      result is inexact
// Build option FLOAT_MULTI_SUBNORMAL_EN: when defined, subnormal operands and
// results are handled by gradual underflow; otherwise subnormal operands are
// treated as zero and results below 2^-14 flush to zero.
module float_multi
  import float_multi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        nan,
  output logic        precision_lost
);

  localparam logic signed [7:0] BIAS_S = 8'(BIAS);
  localparam logic signed [7:0] EMIN_S = 8'(1 - BIAS);

  fp16_t a, b;
  assign a = num1;
  assign b = num2;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
  assign a_nan = (a.exp == 5'(EXP_MAX)) && (a.frac != '0);
  assign b_nan = (b.exp == 5'(EXP_MAX)) && (b.frac != '0);
  assign a_inf = (a.exp == 5'(EXP_MAX)) && (a.frac == '0);
  assign b_inf = (b.exp == 5'(EXP_MAX)) && (b.frac == '0);
  assign sign  = a.sign ^ b.sign;

  // Significands always leave unpacking with bit 10 set (nonzero operands).
  logic [10:0]       sig_a, sig_b;
  logic signed [7:0] exp_a, exp_b;

`ifdef FLOAT_MULTI_SUBNORMAL_EN
  logic [3:0] lz_a, lz_b;

  fp16_lzc11 u_lzc_a (.in_i({a.exp != '0, a.frac}), .cnt_o(lz_a));
  fp16_lzc11 u_lzc_b (.in_i({b.exp != '0, b.frac}), .cnt_o(lz_b));

  assign a_zero = (a.exp == '0) && (a.frac == '0);
  assign b_zero = (b.exp == '0) && (b.frac == '0);
  assign sig_a  = {a.exp != '0, a.frac} << lz_a;
  assign sig_b  = {b.exp != '0, b.frac} << lz_b;
  assign exp_a  = (a.exp == '0) ? EMIN_S - $signed({4'b0, lz_a})
                                : $signed({3'b0, a.exp}) - BIAS_S;
  assign exp_b  = (b.exp == '0) ? EMIN_S - $signed({4'b0, lz_b})
                                : $signed({3'b0, b.exp}) - BIAS_S;
`else
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign sig_a  = {1'b1, a.frac};
  assign sig_b  = {1'b1, b.frac};
  assign exp_a  = $signed({3'b0, a.exp}) - BIAS_S;
  assign exp_b  = $signed({3'b0, b.exp}) - BIAS_S;
`endif

  logic [21:0]       prod, m22;
  logic signed [7:0] be;

  assign prod = sig_a * sig_b;
  // Leading one lands in bit 21: [20:11] fraction, [10] guard, [9] round, rest sticky.
  assign m22  = prod[21] ? prod : {prod[20:0], 1'b0};
  assign be   = exp_a + exp_b + BIAS_S + $signed({7'b0, prod[21]});

  logic [21:0] m_den;
  logic        sticky_x;
  logic [6:0]  exp_base;
  logic        uf_flush;

`ifdef FLOAT_MULTI_SUBNORMAL_EN
  logic signed [7:0] diff;
  logic [4:0]        shamt;
  logic [43:0]       shifted;

  // Denormalise into subnormal range; shifts of 23+ leave only sticky.
  assign diff     = 8'sd1 - be;
  assign shamt    = (diff > 8'sd23) ? 5'd23 : diff[4:0];
  assign shifted  = {m22, 22'b0} >> shamt;
  assign uf_flush = 1'b0;

  always_comb begin
    if (be <= 8'sd0) begin
      m_den    = shifted[43:22];
      sticky_x = |shifted[21:0];
      exp_base = 7'd0;
    end else begin
      m_den    = m22;
      sticky_x = 1'b0;
      exp_base = 7'(be - 8'sd1);
    end
  end
`else
  assign m_den    = m22;
  assign sticky_x = 1'b0;
  assign exp_base = 7'(be - 8'sd1);
  assign uf_flush = (be <= 8'sd0);
`endif

  logic        g_bit, r_bit, s_bit, rnd_up, inexact;
  logic [16:0] enc;

  assign g_bit   = m_den[10];
  assign r_bit   = m_den[9];
  assign s_bit   = (|m_den[8:0]) | sticky_x;
  assign rnd_up  = g_bit & (r_bit | s_bit | m_den[11]);
  assign inexact = g_bit | r_bit | s_bit;
  // Adding the full significand (hidden bit included) onto exp_base lets the
  // hidden bit, mantissa carry-out and subnormal->normal promotion all ripple
  // into the exponent field.
  assign enc = {exp_base, 10'b0} + {6'b0, m_den[21:11]} + 17'(rnd_up);

  logic [15:0] result_d, result_q;
  logic        ovf_d, ovf_q, zero_d, zero_q, nan_d, nan_q, pl_d, pl_q;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    zero_d   = 1'b0;
    nan_d    = 1'b0;
    pl_d     = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result_d = QNAN;
      nan_d    = 1'b1;
    end else if (a_inf || b_inf) begin
      result_d = {sign, POS_INF[14:0]};
    end else if (a_zero || b_zero) begin
      result_d = {sign, 15'b0};
      zero_d   = 1'b1;
    end else if (uf_flush) begin
      result_d = {sign, 15'b0};
      zero_d   = 1'b1;
      pl_d     = 1'b1;
    end else if (enc[16:10] >= 7'(EXP_MAX)) begin
      result_d = {sign, POS_INF[14:0]};
      ovf_d    = 1'b1;
      pl_d     = 1'b1;
    end else begin
      result_d = {sign, enc[14:0]};
      zero_d   = (enc[14:0] == '0);
      pl_d     = inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      nan_q    <= 1'b0;
      pl_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      nan_q    <= nan_d;
      pl_q     <= pl_d;
    end
  end

  assign result         = result_q;
  assign overflow       = ovf_q;
  assign zero           = zero_q;
  assign nan            = nan_q;
  assign precision_lost = pl_q;

endmodule

// File: tb/tb_float_multi.sv
// tb_float_multi
// Directed and randomized checks of float_multi against an exact-arithmetic
// FP16 reference model. Packed observation: {result, overflow, zero, nan,
// precision_lost}.
module tb_float_multi;

`ifdef FLOAT_MULTI_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num1 = '0, num2 = '0;
  logic [15:0] result;
  logic        overflow, zero, nan, precision_lost;

  int n_checks = 0;
  int n_errors = 0;

  float_multi dut (
    .clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2),
    .result(result), .overflow(overflow), .zero(zero), .nan(nan),
    .precision_lost(precision_lost)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] observed();
    return {result, overflow, zero, nan, precision_lost};
  endfunction

  task automatic check_val(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got res=%h flags(ovf,zero,nan,pl)=%b, expected res=%h flags=%b",
               tag, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Exact reference: value = P * 2^e2 with integer P, then RNE onto the FP16 grid.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic   s;
    int     ea, eb, fa, fb, xa, xb, e2, msb, e, q, sh, be;
    longint ma, mb, p, n, rem, half;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inex;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    a_nan  = (ea == 31) && (fa != 0);
    b_nan  = (eb == 31) && (fb != 0);
    a_inf  = (ea == 31) && (fa == 0);
    b_inf  = (eb == 31) && (fb == 0);
    a_zero = (ea == 0) && ((fa == 0) || !SUB_EN);
    b_zero = (eb == 0) && ((fb == 0) || !SUB_EN);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      return {16'h7E00, 4'b0010};
    if (a_inf || b_inf) return {s, 15'h7C00, 4'b0000};
    if (a_zero || b_zero) return {s, 15'h0000, 4'b0100};
    ma = (ea != 0) ? longint'(1024 + fa) : longint'(fa);
    mb = (eb != 0) ? longint'(1024 + fb) : longint'(fb);
    xa = (ea != 0) ? ea - 25 : -24;
    xb = (eb != 0) ? eb - 25 : -24;
    p  = ma * mb;
    e2 = xa + xb;
    msb = 0;
    for (int i = 0; i < 24; i++) if (p[i]) msb = i;
    e = msb + e2;
    if (!SUB_EN && e < -14) return {s, 15'h0000, 4'b0101};
    q  = ((e > -14) ? e : -14) - 10;
    sh = q - e2;
    if (sh <= 0) begin
      n = p << (-sh);
      inex = 1'b0;
    end else if (sh > 60) begin
      n = 0;
      inex = 1'b1;
    end else begin
      n    = p >> sh;
      rem  = p - (n << sh);
      half = longint'(1) << (sh - 1);
      inex = (rem != 0);
      if ((rem > half) || ((rem == half) && n[0])) n++;
    end
    if (n >= 2048) begin
      n = n >> 1;
      q++;
    end
    if (n >= 1024) begin
      be = q + 25;
      n  = n - 1024;
    end else begin
      be = 0;
    end
    if (be >= 31) return {s, 15'h7C00, 4'b1001};
    return {s, 5'(be), 10'(n), 1'b0, (be == 0 && n == 0), 1'b0, inex};
  endfunction

  logic [15:0] va [9];
  logic [15:0] vb [9];
  logic [19:0] vexp [9];

  task automatic apply_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [19:0] exp_const);
    @(negedge clk);
    num1 = a;
    num2 = b;
    @(negedge clk);
    check_val(tag, observed(), exp_const);
    check_val({tag, "_model"}, observed(), model(a, b));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [19:0] exp_prev;

    va   = '{16'h54A5, 16'h4689, 16'hC0B0, 16'h00E0, 16'h42C0,
             16'h7C00, 16'h42C0, 16'h7BFF, 16'h00B8};
    vb   = '{16'h10CC, 16'h0025, 16'h1CC0, 16'h5060, 16'h7C00,
             16'h0000, 16'h0000, 16'h4000, 16'h0080};
`ifdef FLOAT_MULTI_SUBNORMAL_EN
    vexp = '{{16'h2992, 4'b0001}, {16'h00F2, 4'b0001}, {16'hA191, 4'b0000},
             {16'h0FA8, 4'b0000}, {16'h7C00, 4'b0000}, {16'h7E00, 4'b0010},
             {16'h0000, 4'b0100}, {16'h7C00, 4'b1001}, {16'h0000, 4'b0101}};
`else
    vexp = '{{16'h2992, 4'b0001}, {16'h0000, 4'b0100}, {16'hA191, 4'b0000},
             {16'h0000, 4'b0100}, {16'h7C00, 4'b0000}, {16'h7E00, 4'b0010},
             {16'h0000, 4'b0100}, {16'h7C00, 4'b1001}, {16'h0000, 4'b0100}};
`endif

    #2;
    check_val("reset_init", observed(), 20'h0);
    num1 = 16'h54A5;
    num2 = 16'h10CC;
    @(negedge clk);
    check_val("reset_hold", observed(), 20'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      apply_vec($sformatf("vec%0d", i), va[i], vb[i], vexp[i]);

    // Asynchronous reset mid-stream, then exact one-edge latency on release.
    apply_vec("pre_rst", 16'h54A5, 16'h10CC, {16'h2992, 4'b0001});
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async", observed(), 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    num1  = 16'hC0B0;
    num2  = 16'h1CC0;
    #1;
    check_val("rst_release", observed(), 20'h0);
    @(negedge clk);
    check_val("rst_first", observed(), {16'hA191, 4'b0000});

    // Back-to-back random stream: each negedge checks the previous operands.
    exp_prev = model(num1, num2);
    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra[14:10] = 5'($urandom_range(0, 3) == 0 ? 31 : $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rb[14:10] = 5'($urandom_range(0, 3) == 0 ? 31 : $urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ra[9:0] = '0;
      if ($urandom_range(0, 15) == 0) rb[9:0] = '0;
      @(negedge clk);
      check_val("rand", observed(), exp_prev);
      num1 = ra;
      num2 = rb;
      exp_prev = model(ra, rb);
    end
    @(negedge clk);
    check_val("rand_last", observed(), exp_prev);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
